echo_effect: RTL and testbench
==============================

Name: echo_effect

Overview:
- Feedback echo (delay-line) effect inside effect_module, on the 25 MHz clock domain.
- Pulls 16-bit mono samples from effect_controler's output FIFO via i_data_ready/o_read_enable.
- Mixes each sample with an attenuated copy of the output from delay_depth samples earlier, and pushes the result back into effect_controler's input FIFO via o_data_valid.
- Delay line is a circular single-port buffer, inferred as BRAM.

Parameters:
- d_width, 16: sample width, signed two's complement.
- addr_width, 12: delay-line address width.
- delay_depth, 4096: echo delay in samples; must equal 2**addr_width.
- gain_shift, 1: feedback gain = 2**-gain_shift (arithmetic right shift); valid range 0..d_width-1.

Ports:
- clk  input  1  25 MHz effect clock.
- reset_n  input  1  asynchronous active-low reset.
- i_enable  input  1  1 = echo applied; 0 = bypass. Sampled in LATCH state.
- i_data_ready  input  1  upstream FIFO not empty.
- i_data  input  d_width  upstream FIFO read data; valid one cycle after o_read_enable.
- o_read_enable  output  1  single-cycle FIFO read strobe.
- i_out_ready  input  1  downstream FIFO not full.
- o_data  output  d_width  processed sample.
- o_data_valid  output  1  single-cycle write strobe for o_data.
- o_busy  output  1  high while in CLEAR state.

Behaviour:
- Reset (async assert, sync release):
  - State = CLEAR; clear pointer = 0; wr_ptr = 0.
  - o_read_enable = 0, o_data_valid = 0, o_data = 0, o_busy = 1.
- CLEAR:
  - Writes 0 to the address given by the clear pointer, one location per cycle.
  - After writing address delay_depth-1, goes to IDLE and drops o_busy.
  - Duration is exactly delay_depth cycles after reset release.
  - o_read_enable is never asserted in CLEAR.
- IDLE: if i_data_ready = 1, go to READ; else stay.
- READ (1 cycle):
  - o_read_enable = 1.
  - Delay-line read issued at wr_ptr; this location holds y[n - delay_depth].
  - Go to LATCH.
- LATCH (1 cycle):
  - Capture x = i_data and d = memory read data.
  - Capture i_enable.
  - Go to CALC.
- CALC (1 cycle), registered result y:
  - sum = sign-extended x (d_width+2 bits) + (d >>> gain_shift).
  - Saturate: sum > 2**(d_width-1)-1 gives 0x7FFF; sum < -2**(d_width-1) gives 0x8000.
  - If the captured i_enable = 0: y = x, and the delay line is still written with x, so the echo tail resumes seamlessly on re-enable.
  - Go to WRITE.
- WRITE:
  - While i_out_ready = 0: hold the state; o_data holds y; o_data_valid = 0; no memory write.
  - When i_out_ready = 1: o_data_valid = 1 for exactly one cycle with o_data = y; memory[wr_ptr] = y; wr_ptr = wr_ptr + 1 mod delay_depth (wraps from delay_depth-1 to 0); go to IDLE.
- Latency and throughput:
  - o_read_enable rises to o_data_valid rises = 3 cycles minimum.
  - At most one sample in flight.
  - Throughput 1 sample per 5 cycles, far above the audio rate.
- o_data stays at the last value between strobes.
- Strobe rules:
  - o_read_enable and o_data_valid are never high in the same cycle.
  - o_read_enable is never asserted while a sample is pending in LATCH/CALC/WRITE.
- Simultaneous events:
  - i_data_ready deasserting during LATCH/CALC/WRITE has no effect.
  - A change of i_enable is only honoured at the next LATCH.
- Reset mid-operation: any state returns immediately to CLEAR.
  - An in-flight sample is discarded (no o_data_valid).
  - The delay line is fully re-zeroed.
- Memory: one read port (READ state) and one write port (CLEAR/WRITE states), never the same cycle. Synchronous read, 1-cycle latency.

Test Plan:
- Run with delay_depth=8, addr_width=3, gain_shift=1. Stub upstream FIFO with 1-cycle read latency and downstream sink with controllable ready.
- Clear: release reset -> o_busy high exactly 8 cycles, then low. No o_read_enable before then, even with i_data_ready=1 throughout.
- Impulse:
  - Stimulus: feed 0x4000 followed by 23 zeros, i_enable=1.
  - Required: outputs 0x4000 at n=0, 0x2000 at n=8, 0x1000 at n=16, 0 elsewhere.
  - Required: every o_data_valid occurs exactly 3 cycles after its o_read_enable.
- Saturation:
  - Constant 0x7000 for 16 samples -> n=0..7 output 0x7000; n=8..15 output 0x7FFF.
  - Repeat with 0x9000 -> n=8..15 output 0x8000.
- Backpressure:
  - Stimulus: hold i_out_ready=0 for 10 cycles while the sample 0x1234 is in WRITE.
  - Required: o_data = 0x1234 steady; no o_data_valid; no further o_read_enable.
  - Required: on ready, a single strobe; the delay line is written once (check the echo 0x091A at n+8).
- Bypass:
  - Impulse 0x4000 with i_enable=0 for the first 8 samples, then i_enable=1.
  - Required: n=0 output 0x4000; n=8 output 0x2000 (bypassed data was still recorded).
- Reset mid-op:
  - Assert reset_n low during CALC after a 0x4000 impulse; release.
  - Required: no o_data_valid for the in-flight sample; 8 clear cycles.
  - Required: then feed 16 zeros -> all outputs 0 (no residual echo).

Source files
------------

// File: rtl/echo_effect.sv
// echo_effect: feedback echo (delay-line) effect.
// Pulls one sample at a time from the upstream FIFO and mixes it with an
// attenuated copy of the output from delay_depth samples earlier. The result
// is pushed to the downstream FIFO and also recorded in the delay line.
//
// Ports:
//   clk            effect clock
//   reset_n        asynchronous active-low reset
//   i_enable       1 = echo applied, 0 = bypass (taken in LATCH)
//   i_data_ready   upstream FIFO not empty
//   i_data         upstream FIFO read data, valid one cycle after o_read_enable
//   o_read_enable  single-cycle upstream read strobe
//   i_out_ready    downstream FIFO not full
//   o_data         processed sample, held between strobes
//   o_data_valid   single-cycle downstream write strobe
//   o_busy         high while the delay line is being zeroed
//
// state   | meaning
// CLEAR   | zero one delay-line location per cycle
// IDLE    | wait for an upstream sample
// READ    | strobe the FIFO, read the delay line at wr_ptr
// LATCH   | capture sample, delayed output and enable
// CALC    | compute the saturated mix into y
// WRITE   | wait for downstream room, emit y and record it
module echo_effect #(
  parameter int d_width     = 16,
  parameter int addr_width  = 12,
  parameter int delay_depth = 4096,
  parameter int gain_shift  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_enable,
  input  logic               i_data_ready,
  input  logic [d_width-1:0] i_data,
  output logic               o_read_enable,
  input  logic               i_out_ready,
  output logic [d_width-1:0] o_data,
  output logic               o_data_valid,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_READ,
    S_LATCH,
    S_CALC,
    S_WRITE
  } state_t;

  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(delay_depth - 1);

  state_t                state_q, state_d;
  logic [addr_width-1:0] clr_ptr_q, clr_ptr_d;
  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [d_width-1:0]    x_q, d_q, y_q;
  logic                  en_q;
  logic [d_width-1:0]    rd_data_q;
  logic [d_width-1:0]    mem_q [0:delay_depth-1];

  logic                  mem_we;
  logic [addr_width-1:0] mem_waddr;
  logic [d_width-1:0]    mem_wdata;

  logic signed [d_width+1:0] x_ext, d_ext, sum;
  logic [d_width-1:0]        y_calc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      wr_ptr_q  <= '0;
      x_q       <= '0;
      d_q       <= '0;
      y_q       <= '0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      if (state_q == S_LATCH) begin
        x_q  <= i_data;
        d_q  <= rd_data_q;
        en_q <= i_enable;
      end
      if (state_q == S_CALC) begin
        y_q <= y_calc;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    clr_ptr_d     = clr_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    o_read_enable = 1'b0;
    o_data_valid  = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = wr_ptr_q;
    mem_wdata     = y_q;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (i_data_ready) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        o_read_enable = 1'b1;
        state_d       = S_LATCH;
      end
      S_LATCH: state_d = S_CALC;
      S_CALC:  state_d = S_WRITE;
      S_WRITE: begin
        if (i_out_ready) begin
          o_data_valid = 1'b1;
          mem_we       = 1'b1;
          wr_ptr_d     = wr_ptr_q + 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Two guard bits: the 16-bit sample plus the shifted feedback can exceed
  // the output range; it fits only when the top three sum bits agree.
  always_comb begin
    x_ext = {{2{x_q[d_width-1]}}, x_q};
    d_ext = $signed({{2{d_q[d_width-1]}}, d_q}) >>> gain_shift;
    sum   = x_ext + d_ext;
    if ((sum[d_width+1 -: 3] == 3'b000) || (sum[d_width+1 -: 3] == 3'b111)) begin
      y_calc = sum[d_width-1:0];
    end else if (sum[d_width+1]) begin
      y_calc = {1'b1, {(d_width-1){1'b0}}};
    end else begin
      y_calc = {1'b0, {(d_width-1){1'b1}}};
    end
    // Bypass still records x so the tail picks up cleanly on re-enable.
    if (!en_q) begin
      y_calc = x_q;
    end
  end

  // Delay line: no reset so it maps onto block RAM; CLEAR zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
    if (state_q == S_READ) begin
      rd_data_q <= mem_q[wr_ptr_q];
    end
  end

  assign o_data = y_q;
  assign o_busy = (state_q == S_CLEAR);

endmodule

// File: tb/tb_echo_effect.sv
module tb_echo_effect;
  localparam int DEPTH = 8;
  localparam int GS    = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_data_ready = 1'b0;
  logic [15:0] i_data = '0;
  logic        o_read_enable;
  logic        i_out_ready = 1'b1;
  logic [15:0] o_data;
  logic        o_data_valid;
  logic        o_busy;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  int          mdl_mem[DEPTH];
  int          mdl_ptr = 0;
  int          cyc = 0;
  int          re_cyc = 0;
  bit          pending = 0;
  bit          exact_lat = 1;

  echo_effect #(
    .d_width(16), .addr_width(3), .delay_depth(DEPTH), .gain_shift(GS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_enable(i_enable),
    .i_data_ready(i_data_ready), .i_data(i_data),
    .o_read_enable(o_read_enable), .i_out_ready(i_out_ready),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_busy(o_busy)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] x, input bit en);
    int xs, sum, y;
    xs = int'($signed(x));
    if (en) begin
      sum = xs + (mdl_mem[mdl_ptr] >>> GS);
      if (sum > 32767) y = 32767;
      else if (sum < -32768) y = -32768;
      else y = sum;
    end else begin
      y = xs;
    end
    mdl_mem[mdl_ptr] = y;
    mdl_ptr = (mdl_ptr + 1) % DEPTH;
    return y[15:0];
  endfunction

  // Output monitor: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      pending = 0;
    end else begin
      if (o_read_enable || o_data_valid)
        chk("strobe_overlap", o_read_enable & o_data_valid, 0);
      if (o_read_enable) begin
        chk("read_while_busy_or_pending", {o_busy, pending}, 0);
        pending = 1;
        re_cyc  = cyc;
      end
      if (o_data_valid) begin
        pending = 0;
        chk("valid_has_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("out_data", o_data, exp_q.pop_front());
        if (exact_lat) chk("latency", cyc - re_cyc, 3);
        else chk("latency_min", (cyc - re_cyc) >= 3, 1);
      end
    end
  end

  // Upstream FIFO stub: serves x one cycle after the read strobe, then
  // scrambles data/enable once LATCH has passed.
  task automatic do_sample(input logic [15:0] x, input bit en);
    int cnt;
    exp_q.push_back(model_step(x, en));
    i_data_ready = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!o_read_enable && cnt < 50);
    chk("read_strobe_seen", o_read_enable, 1);
    if (!o_read_enable) begin
      void'(exp_q.pop_back());
      i_data_ready = 1'b0;
      return;
    end
    i_data       = x;
    i_enable     = en;
    i_data_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_data   = 16'hDEAD;
    i_enable = ~en;
  endtask

  task automatic do_reset(input bit drain);
    int cnt;
    if (drain) begin
      cnt = 0;
      while (exp_q.size() != 0 && cnt < 30) begin
        @(negedge clk);
        cnt++;
      end
      chk("drain_before_reset", exp_q.size(), 0);
      @(negedge clk);
    end
    reset_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 0;
    mdl_ptr = 0;
    i_data_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", o_busy, 1);
    chk("rst_read_enable", o_read_enable, 0);
    chk("rst_data_valid", o_data_valid, 0);
    chk("rst_data", o_data, 0);
    reset_n = 1'b1;
    cnt = 0;
    while (o_busy && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("clear_cycles", cnt, 8);
    i_data_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    @(negedge clk);
    do_reset(0);

    // Impulse: echoes at n=8 and n=16
    do_sample(16'h4000, 1);
    for (int i = 1; i < 24; i++) do_sample(16'h0000, 1);

    // Positive and negative saturation
    do_reset(1);
    repeat (16) do_sample(16'h7000, 1);
    do_reset(1);
    repeat (16) do_sample(16'h9000, 1);

    // Backpressure while 0x1234 sits in WRITE
    do_reset(1);
    exact_lat   = 0;
    i_out_ready = 1'b0;
    do_sample(16'h1234, 1);
    @(negedge clk);
    i_data_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_data_held", o_data, 16'h1234);
      chk("bp_no_valid", o_data_valid, 0);
      chk("bp_no_read", o_read_enable, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    i_out_ready  = 1'b1;
    i_data_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exact_lat = 1;
    repeat (8) do_sample(16'h0000, 1);

    // Bypass for the first 8 samples, still recorded in the delay line
    do_reset(1);
    do_sample(16'h4000, 0);
    repeat (7) do_sample(16'h0000, 0);
    repeat (9) do_sample(16'h0000, 1);

    // Reset during CALC of a second impulse, then confirm no residual echo
    do_reset(1);
    do_sample(16'h4000, 1);
    do_sample(16'h4000, 1);
    do_reset(0);
    repeat (16) do_sample(16'h0000, 1);

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    chk("final_drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
